cr_rbus_ring_master: RTL
========================

Name: cr_rbus_ring_master

Overview:
- Head-of-ring initiator for the rbus register ring; the counterpart of the per-block ring responder nodes (regfile + nx_rbus_ring).
- Accepts one register read/write from a host-side request port and launches it as a single-cycle strobe on the outbound ring.
- Waits for ack/err_ack to return on the inbound ring, then presents read data and status on a response port.
- Sits at ring origin in the top-level config/CSR bridge; one transaction outstanding at a time.

Parameters:
- N_RBUS_ADDR_BITS, 16, ring address width.
- N_RBUS_DATA_BITS, 32, ring data width.
- TIMEOUT_CYCLES, 1024, cycles waited in WAIT before forcing a timeout response (min 2).
- TO_CNT_BITS, 11, timeout counter width; must hold TIMEOUT_CYCLES.

Ports:
- clk  in  1  clock.
- rst  in  1  synchronous active-high reset.
- req_valid  in  1  host request valid.
- req_ready  out  1  master can accept a request.
- req_wr  in  1  1=write, 0=read.
- req_addr  in  N_RBUS_ADDR_BITS  target register address.
- req_wdata  in  N_RBUS_DATA_BITS  write data.
- rsp_valid  out  1  response valid.
- rsp_ready  in  1  host accepts response.
- rsp_rdata  out  N_RBUS_DATA_BITS  read data; 0 for writes, error, timeout.
- rsp_err  out  1  err_ack received or timeout.
- rsp_timeout  out  1  no ack within TIMEOUT_CYCLES.
- rbus_addr_o  out  N_RBUS_ADDR_BITS  outbound ring address.
- rbus_wr_strb_o  out  1  outbound write strobe.
- rbus_wr_data_o  out  N_RBUS_DATA_BITS  outbound write data.
- rbus_rd_strb_o  out  1  outbound read strobe.
- rbus_rd_data_o  out  N_RBUS_DATA_BITS  outbound read data; driven 0.
- rbus_ack_o  out  1  outbound ack; driven 0.
- rbus_err_ack_o  out  1  outbound err_ack; driven 0.
- rbus_rd_data_i  in  N_RBUS_DATA_BITS  returning read data.
- rbus_ack_i  in  1  returning ack.
- rbus_err_ack_i  in  1  returning error ack.
- stray_ack  out  1  sticky: ack/err_ack seen while not in WAIT; cleared only by rst.

Interface decisions: one clock, clk. Reset rst is synchronous and active-high.

Behaviour:
- Reset: state=IDLE. req_ready=0 during rst, 1 in the first cycle after rst. rsp_valid, rsp_err, rsp_timeout, stray_ack=0. rsp_rdata=0. All rbus_*_o=0. Timeout counter=0.
- All outputs registered.
- IDLE: req_ready=1. On req_valid&&req_ready:
  - Capture addr, wdata, wr.
  - Go to ISSUE.
- ISSUE (exactly 1 cycle):
  - rbus_addr_o=addr.
  - rbus_wr_strb_o=wr, rbus_rd_strb_o=!wr.
  - rbus_wr_data_o=wdata if wr, else 0.
  - Go to WAIT.
  - Request-to-strobe latency: strobe is high the cycle after acceptance.
- WAIT:
  - Strobes=0. rbus_addr_o and rbus_wr_data_o hold their values.
  - Counter increments each cycle.
  - On rbus_ack_i: rsp_err=0; rsp_rdata=rbus_rd_data_i for reads, 0 for writes. Go to RESP.
  - On rbus_err_ack_i: rsp_err=1, rsp_rdata=0. Go to RESP.
  - ack and err_ack in the same cycle: err wins.
  - Counter==TIMEOUT_CYCLES-1 with no ack: rsp_err=1, rsp_timeout=1, rsp_rdata=0. Go to RESP.
  - Ack on the timeout cycle: ack wins, no timeout.
- RESP:
  - rsp_valid=1; response fields held stable until rsp_valid&&rsp_ready.
  - On handshake: rsp_valid=0, counter=0, rbus_addr_o=0, rbus_wr_data_o=0. Go to IDLE.
  - req_ready=0 in RESP, so the next request is accepted no earlier than the cycle after the response handshake.
- Stray acks: ack/err_ack arriving in IDLE, ISSUE, or RESP (e.g. a late ack after timeout) are ignored for response purposes and set stray_ack.
- Passthrough: rbus_rd_data_o, rbus_ack_o, rbus_err_ack_o are constant 0; the master originates no read data or acks.
- rst mid-transaction: immediate return to reset values next edge. Any in-flight ack is then treated as stray only if it arrives after rst deasserts.

Test Plan:
- Write addr=0x0040 data=0xDEADBEEF; responder acks 3 cycles after strobe -> exactly one cycle rbus_wr_strb_o=1, addr 0x0040, data 0xDEADBEEF; rsp_valid with rsp_err=0, rsp_rdata=0.
- Read addr=0x0104; ack with rbus_rd_data_i=0x12345678 -> rbus_rd_strb_o for one cycle; rsp_rdata=0x12345678, rsp_err=0, rsp_timeout=0.
- Read with err_ack only -> rsp_err=1, rsp_timeout=0, rsp_rdata=0. Repeat with ack+err_ack in the same cycle -> same result.
- No ack, TIMEOUT_CYCLES=16 -> rsp_valid exactly 16 WAIT cycles after strobe, rsp_timeout=1, rsp_err=1. Then inject ack in IDLE -> stray_ack=1, no new rsp_valid.
- Hold rsp_ready=0 for 5 cycles with req_valid=1 -> response fields stable, req_ready=0. Next request accepted only after the handshake.
- Assert rst in WAIT -> next cycle all outputs 0, state IDLE; a fresh read completes normally.

Source files
------------

// File: rtl/cr_rbus_ring_master.sv
// rtl/cr_rbus_ring_master.sv - rbus ring head initiator: one outstanding register access, strobe out, ack/err_ack/timeout back
module cr_rbus_ring_master #(
    parameter int N_RBUS_ADDR_BITS = 16,
    parameter int N_RBUS_DATA_BITS = 32,
    parameter int TIMEOUT_CYCLES   = 1024,
    parameter int TO_CNT_BITS      = 11
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic                        req_valid,
    output logic                        req_ready,
    input  logic                        req_wr,
    input  logic [N_RBUS_ADDR_BITS-1:0] req_addr,
    input  logic [N_RBUS_DATA_BITS-1:0] req_wdata,
    output logic                        rsp_valid,
    input  logic                        rsp_ready,
    output logic [N_RBUS_DATA_BITS-1:0] rsp_rdata,
    output logic                        rsp_err,
    output logic                        rsp_timeout,
    output logic [N_RBUS_ADDR_BITS-1:0] rbus_addr_o,
    output logic                        rbus_wr_strb_o,
    output logic [N_RBUS_DATA_BITS-1:0] rbus_wr_data_o,
    output logic                        rbus_rd_strb_o,
    output logic [N_RBUS_DATA_BITS-1:0] rbus_rd_data_o,
    output logic                        rbus_ack_o,
    output logic                        rbus_err_ack_o,
    input  logic [N_RBUS_DATA_BITS-1:0] rbus_rd_data_i,
    input  logic                        rbus_ack_i,
    input  logic                        rbus_err_ack_i,
    output logic                        stray_ack
);

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_ISSUE,
        ST_WAIT,
        ST_RESP
    } state_t;

    localparam logic [TO_CNT_BITS-1:0] TO_LAST = TO_CNT_BITS'(TIMEOUT_CYCLES - 1);

    state_t                 state;
    logic                   wr_q;
    logic [TO_CNT_BITS-1:0] to_cnt;
    logic                   ack_any;

    assign ack_any = rbus_ack_i | rbus_err_ack_i;

    // The head of the ring only originates strobes; returning fields are never driven.
    assign rbus_rd_data_o = '0;
    assign rbus_ack_o     = 1'b0;
    assign rbus_err_ack_o = 1'b0;

    always_ff @(posedge clk) begin
        if (rst) begin
            state          <= ST_IDLE;
            wr_q           <= 1'b0;
            to_cnt         <= '0;
            req_ready      <= 1'b0;
            rsp_valid      <= 1'b0;
            rsp_rdata      <= '0;
            rsp_err        <= 1'b0;
            rsp_timeout    <= 1'b0;
            rbus_addr_o    <= '0;
            rbus_wr_strb_o <= 1'b0;
            rbus_rd_strb_o <= 1'b0;
            rbus_wr_data_o <= '0;
            stray_ack      <= 1'b0;
        end else begin
            if (ack_any && state != ST_WAIT) begin
                stray_ack <= 1'b1;
            end
            case (state)
                ST_IDLE: begin
                    if (req_valid && req_ready) begin
                        req_ready      <= 1'b0;
                        wr_q           <= req_wr;
                        rbus_addr_o    <= req_addr;
                        rbus_wr_strb_o <= req_wr;
                        rbus_rd_strb_o <= !req_wr;
                        rbus_wr_data_o <= req_wr ? req_wdata : '0;
                        state          <= ST_ISSUE;
                    end else begin
                        req_ready <= 1'b1;
                    end
                end
                ST_ISSUE: begin
                    rbus_wr_strb_o <= 1'b0;
                    rbus_rd_strb_o <= 1'b0;
                    to_cnt         <= '0;
                    state          <= ST_WAIT;
                end
                ST_WAIT: begin
                    to_cnt <= to_cnt + 1'b1;
                    // err_ack beats ack; any ack beats a timeout on the same cycle
                    if (rbus_err_ack_i) begin
                        rsp_err     <= 1'b1;
                        rsp_timeout <= 1'b0;
                        rsp_rdata   <= '0;
                        rsp_valid   <= 1'b1;
                        state       <= ST_RESP;
                    end else if (rbus_ack_i) begin
                        rsp_err     <= 1'b0;
                        rsp_timeout <= 1'b0;
                        rsp_rdata   <= wr_q ? '0 : rbus_rd_data_i;
                        rsp_valid   <= 1'b1;
                        state       <= ST_RESP;
                    end else if (to_cnt == TO_LAST) begin
                        rsp_err     <= 1'b1;
                        rsp_timeout <= 1'b1;
                        rsp_rdata   <= '0;
                        rsp_valid   <= 1'b1;
                        state       <= ST_RESP;
                    end
                end
                ST_RESP: begin
                    if (rsp_ready) begin
                        rsp_valid      <= 1'b0;
                        to_cnt         <= '0;
                        rbus_addr_o    <= '0;
                        rbus_wr_data_o <= '0;
                        req_ready      <= 1'b1;
                        state          <= ST_IDLE;
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule
